initiator: RTL

INITIATOR -- requirements
Module: initiator

---
 rtl/initiator_pkg.sv | 26 ++
 rtl/initiator_if.sv | 43 ++++
 rtl/initiator.sv | 123 ++++++++++++
 3 files changed

// File: rtl/initiator_pkg.sv
// Shared types and constants for the single-outstanding bus initiator.
// Consumed by the interface, the initiator core and its bench.
package initiator_pkg;

  localparam int unsigned ADDR_W                 = 16;
  localparam int unsigned DATA_W                 = 8;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [7:0]        timer_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WAIT_ACK,
    RESP
  } state_e;

  // Read data is only trusted when the target flags it valid alongside the ack.
  function automatic data_t capture_rdata(input logic valid, input data_t data);
    return valid ? data : '0;
  endfunction

endpackage

// File: rtl/initiator_if.sv
// User request/response channel plus target bus, bundled for the initiator.
// master = the initiator's view, slave = the user/target environment's view.
interface initiator_if
  import initiator_pkg::*;
;
  // user side
  logic  req_valid;
  logic  req_ready;
  logic  req_rw;
  addr_t req_addr;
  data_t req_wdata;
  logic  resp_valid;
  data_t resp_rdata;
  logic  resp_err;

  // target side
  addr_t init_addr_out;
  logic  init_addr_out_valid;
  data_t init_data_out;
  logic  init_data_out_valid;
  logic  init_rw;
  data_t init_data_in;
  logic  init_data_in_valid;
  logic  init_ack;
  logic  init_ready;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata,
    input  init_data_in, init_data_in_valid, init_ack, init_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output init_addr_out, init_addr_out_valid,
    output init_data_out, init_data_out_valid, init_rw
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata,
    output init_data_in, init_data_in_valid, init_ack, init_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  init_addr_out, init_addr_out_valid,
    input  init_data_out, init_data_out_valid, init_rw
  );

endinterface

// File: rtl/initiator.sv
// Single-outstanding bus initiator: address phase, optional write-data phase, ack wait, response pulse.
// Optional ack timeout is compiled in with `define INITIATOR_TIMEOUT_EN.
module initiator
  import initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic         clk,
  input logic         rst,
  initiator_if.master bus
);

  state_e state_q, state_d;
  logic   rw_q, rw_d;
  addr_t  addr_q, addr_d;
  data_t  wdata_q, wdata_d;
  data_t  rdata_q, rdata_d;
  logic   req_fire;

`ifdef INITIATOR_TIMEOUT_EN
  localparam timer_t TIMEOUT_LAST = timer_t'(TIMEOUT_CYCLES - 1);

  timer_t cnt_q, cnt_d;
  logic   err_q, err_d;
  logic   timeout_hit;

  // Counter sits at zero outside WAIT_ACK, so it is fresh on every entry.
  assign cnt_d       = (state_q == WAIT_ACK) ? cnt_q + 8'd1 : '0;
  assign timeout_hit = (state_q == WAIT_ACK) && (cnt_q == TIMEOUT_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  assign req_fire = bus.req_valid && bus.req_ready;

  // State and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef INITIATOR_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef INITIATOR_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next state and capture updates
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef INITIATOR_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          rw_d    = bus.req_rw;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = '0;
`ifdef INITIATOR_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ADDR;
        end
      end
      ADDR:  state_d = rw_q ? WDATA : WAIT_ACK;
      WDATA: state_d = WAIT_ACK;
      WAIT_ACK: begin
        // Ack is checked first so an ack on the timeout cycle still succeeds.
        if (bus.init_ack) begin
          state_d = RESP;
          rdata_d = rw_q ? '0 : capture_rdata(bus.init_data_in_valid, bus.init_data_in);
`ifdef INITIATOR_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: strobes decode the state, payloads hold the last capture
  always_comb begin
    bus.req_ready           = (state_q == IDLE) && bus.init_ready && !rst;
    bus.init_addr_out_valid = (state_q == ADDR);
    bus.init_data_out_valid = (state_q == WDATA);
    bus.resp_valid          = (state_q == RESP);
    bus.init_addr_out       = addr_q;
    bus.init_data_out       = wdata_q;
    bus.init_rw             = rw_q;
    bus.resp_rdata          = rdata_q;
`ifdef INITIATOR_TIMEOUT_EN
    bus.resp_err            = err_q;
`else
    bus.resp_err            = 1'b0;
`endif
  end

endmodule
